// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter with a bounded hold time, driving the select of a shared 4:1 mux.
// Grant and select are registered; the routed data y is combinational from sel and the inputs.

module mux4_rr_mux #(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    y = a;
    case (sel)
      2'd0: y = a;
      2'd1: y = b;
      2'd2: y = c;
      2'd3: y = d;
      default: y = a;
    endcase
  end
endmodule

// state | meaning
// IDLE  | no requester granted, gnt = 0, sel holds its last value
// BUSY  | one owner granted (sel), hold_q counts its consecutive cycles
module mux4_rr_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] y,
  output logic             y_valid
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [3:0]      gnt_q, gnt_d;
  logic [1:0]      sel_q, sel_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [1:0]      win;
  logic            keep;
  logic [WIDTH-1:0] mux_y;

  // First requester found searching start, start+1, ... modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    rr_pick = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    win     = rr_pick(req, ptr_q);
    keep    = req[sel_q] && (hold_q < HOLD_MAX);
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = 4'b0001 << win;
          sel_d   = win;
          hold_d  = HOLD_ONE;
          ptr_d   = win + 2'd1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (keep) begin
          hold_d = hold_q + HOLD_ONE;
        end else if (|req) begin
          // Searching from owner+1 reaches the owner last, so it only wins as sole requester.
          win    = rr_pick(req, sel_q + 2'd1);
          gnt_d  = 4'b0001 << win;
          sel_d  = win;
          hold_d = HOLD_ONE;
          ptr_d  = win + 2'd1;
        end else begin
          gnt_d   = 4'b0000;
          state_d = IDLE;
        end
      end
      default: begin
        gnt_d   = 4'b0000;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  mux4_rr_mux #(.WIDTH(WIDTH)) u_mux (
    .sel (sel_q),
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .y   (mux_y)
  );

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign y_valid = |gnt_q;
  assign y       = y_valid ? mux_y : '0;
endmodule
